// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
//   Round-robin arbiter sharing one AXI4 read port (AR + R channels) of a
//   memory slave between NUM_M read masters. One burst is outstanding at a
//   time; the grant stays locked until the R beat carrying rlast completes.
//   Burst-length mismatches between ARLEN and the slave's RLAST are flagged
//   in a sticky len_err bit.
//
// Ports
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   M_AXI_ar*            packed per-master AR channel (master k at slice k)
//   M_AXI_arready        per-master, only the granted bit can be high
//   M_AXI_r{id,data,resp,last}  broadcast R payload from the slave
//   M_AXI_rvalid         per-master, only the granted bit can be high
//   M_AXI_rready         per-master
//   S_AXI_ar*, S_AXI_r*  single AXI4 read port towards the slave
//   grant                index of the current or last granted master
//   busy                 high while an address or data phase is in progress
//   len_err              sticky burst-length mismatch flag
module axi_read_arbiter #(
    parameter int NUM_M      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    localparam int GW        = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,

    input  logic [NUM_M*ID_WIDTH-1:0]      M_AXI_arid,
    input  logic [NUM_M*ADDR_WIDTH-1:0]    M_AXI_araddr,
    input  logic [NUM_M*8-1:0]             M_AXI_arlen,
    input  logic [NUM_M-1:0]               M_AXI_arvalid,
    output logic [NUM_M-1:0]               M_AXI_arready,
    output logic [ID_WIDTH-1:0]            M_AXI_rid,
    output logic [DATA_WIDTH-1:0]          M_AXI_rdata,
    output logic [1:0]                     M_AXI_rresp,
    output logic                           M_AXI_rlast,
    output logic [NUM_M-1:0]               M_AXI_rvalid,
    input  logic [NUM_M-1:0]               M_AXI_rready,

    output logic [ID_WIDTH-1:0]            S_AXI_arid,
    output logic [ADDR_WIDTH-1:0]          S_AXI_araddr,
    output logic [7:0]                     S_AXI_arlen,
    output logic [2:0]                     S_AXI_arsize,
    output logic [1:0]                     S_AXI_arburst,
    output logic                           S_AXI_arvalid,
    input  logic                           S_AXI_arready,
    input  logic [ID_WIDTH-1:0]            S_AXI_rid,
    input  logic [DATA_WIDTH-1:0]          S_AXI_rdata,
    input  logic [1:0]                     S_AXI_rresp,
    input  logic                           S_AXI_rlast,
    input  logic                           S_AXI_rvalid,
    output logic                           S_AXI_rready,

    output logic [GW-1:0]                  grant,
    output logic                           busy,
    output logic                           len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic            len_err_q, len_err_d;

    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;
    logic            found;
    logic            ar_hs;
    logic            r_hs;

    logic [ID_WIDTH-1:0]   arid_m   [NUM_M];
    logic [ADDR_WIDTH-1:0] araddr_m [NUM_M];
    logic [7:0]            arlen_m  [NUM_M];

    for (genvar k = 0; k < NUM_M; k++) begin : g_unpack
        assign arid_m[k]   = M_AXI_arid[k*ID_WIDTH +: ID_WIDTH];
        assign araddr_m[k] = M_AXI_araddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign arlen_m[k]  = M_AXI_arlen[k*8 +: 8];
    end

    // AR payload always follows grant, so after reset master 0 is visible.
    assign S_AXI_arid    = arid_m[grant_q];
    assign S_AXI_araddr  = araddr_m[grant_q];
    assign S_AXI_arlen   = arlen_m[grant_q];
    assign S_AXI_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign S_AXI_arburst = 2'b01;

    assign M_AXI_rid   = S_AXI_rid;
    assign M_AXI_rdata = S_AXI_rdata;
    assign M_AXI_rresp = S_AXI_rresp;
    assign M_AXI_rlast = S_AXI_rlast;

    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign len_err = len_err_q;

    always_comb begin
        M_AXI_arready = '0;
        M_AXI_rvalid  = '0;
        S_AXI_arvalid = 1'b0;
        S_AXI_rready  = 1'b0;
        case (state_q)
            ADDR: begin
                S_AXI_arvalid          = M_AXI_arvalid[grant_q];
                M_AXI_arready[grant_q] = S_AXI_arready;
            end
            DATA: begin
                M_AXI_rvalid[grant_q] = S_AXI_rvalid;
                S_AXI_rready          = M_AXI_rready[grant_q];
            end
            default: ;
        endcase
    end

    assign ar_hs = (state_q == ADDR) && S_AXI_arvalid && S_AXI_arready;
    assign r_hs  = (state_q == DATA) && S_AXI_rvalid && S_AXI_rready;

    // Scan requesters starting at rr_ptr, wrapping at NUM_M (which need not
    // be a power of two, hence the explicit wrap compare).
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!found && M_AXI_arvalid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = (cand == GW'(NUM_M - 1)) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // A requester dropping arvalid here simply keeps us waiting.
                if (ar_hs) begin
                    len_d      = arlen_m[grant_q];
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // Mismatch either way: early rlast or missing rlast on
                    // the last expected beat. Routing still obeys rlast.
                    if (S_AXI_rlast != (beat_cnt_q == len_q)) begin
                        len_err_d = 1'b1;
                    end
                    if (S_AXI_rlast) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == GW'(NUM_M - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter
//   Bench for axi_read_arbiter with NUM_M=2. The bench plays both masters and
//   the memory slave; expected AR transfers are queued in predicted grant
//   order, and expected R beats are queued when the slave accepts an address.
module tb_axi_read_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic               ACLK = 1'b0;
    logic               ARESETN;
    logic [NM*IW-1:0]   M_AXI_arid;
    logic [NM*AW-1:0]   M_AXI_araddr;
    logic [NM*8-1:0]    M_AXI_arlen;
    logic [NM-1:0]      M_AXI_arvalid;
    logic [NM-1:0]      M_AXI_arready;
    logic [IW-1:0]      M_AXI_rid;
    logic [DW-1:0]      M_AXI_rdata;
    logic [1:0]         M_AXI_rresp;
    logic               M_AXI_rlast;
    logic [NM-1:0]      M_AXI_rvalid;
    logic [NM-1:0]      M_AXI_rready;
    logic [IW-1:0]      S_AXI_arid;
    logic [AW-1:0]      S_AXI_araddr;
    logic [7:0]         S_AXI_arlen;
    logic [2:0]         S_AXI_arsize;
    logic [1:0]         S_AXI_arburst;
    logic               S_AXI_arvalid;
    logic               S_AXI_arready;
    logic [IW-1:0]      S_AXI_rid;
    logic [DW-1:0]      S_AXI_rdata;
    logic [1:0]         S_AXI_rresp;
    logic               S_AXI_rlast;
    logic               S_AXI_rvalid;
    logic               S_AXI_rready;
    logic               grant;
    logic               busy;
    logic               len_err;

    always #5 ACLK = ~ACLK;

    axi_read_arbiter #(
        .NUM_M      (NM),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .M_AXI_arid    (M_AXI_arid),
        .M_AXI_araddr  (M_AXI_araddr),
        .M_AXI_arlen   (M_AXI_arlen),
        .M_AXI_arvalid (M_AXI_arvalid),
        .M_AXI_arready (M_AXI_arready),
        .M_AXI_rid     (M_AXI_rid),
        .M_AXI_rdata   (M_AXI_rdata),
        .M_AXI_rresp   (M_AXI_rresp),
        .M_AXI_rlast   (M_AXI_rlast),
        .M_AXI_rvalid  (M_AXI_rvalid),
        .M_AXI_rready  (M_AXI_rready),
        .S_AXI_arid    (S_AXI_arid),
        .S_AXI_araddr  (S_AXI_araddr),
        .S_AXI_arlen   (S_AXI_arlen),
        .S_AXI_arsize  (S_AXI_arsize),
        .S_AXI_arburst (S_AXI_arburst),
        .S_AXI_arvalid (S_AXI_arvalid),
        .S_AXI_arready (S_AXI_arready),
        .S_AXI_rid     (S_AXI_rid),
        .S_AXI_rdata   (S_AXI_rdata),
        .S_AXI_rresp   (S_AXI_rresp),
        .S_AXI_rlast   (S_AXI_rlast),
        .S_AXI_rvalid  (S_AXI_rvalid),
        .S_AXI_rready  (S_AXI_rready),
        .grant         (grant),
        .busy          (busy),
        .len_err       (len_err)
    );

    typedef struct {
        int            m;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [IW-1:0] id;
        int            short_at;
    } ar_t;

    typedef struct {
        int            m;
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } r_t;

    ar_t exp_ar[$];
    r_t  exp_r[$];

    // master model
    logic [NM-1:0] m_req;
    logic [AW-1:0] m_addr [NM];
    logic [7:0]    m_len  [NM];
    int            m_again[NM];
    int            rr_mode;

    // slave model
    int            ar_delay;
    int            ar_wait;
    bit            sl_busy;
    logic [AW-1:0] sl_addr;
    logic [IW-1:0] sl_id;
    int            sl_nb;
    int            sl_beat;

    bit            tb_data;
    int            cur_m;
    int            cyc;
    int            sarv_first;
    int            req6_cyc;
    bit            trig6;
    bit            coinc6;
    int            r_cnt;

    int            n_total;
    int            n_bad;

    function automatic logic [IW-1:0] id_of(input int k);
        return IW'(k + 5);
    endfunction

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
        return 32'hDEADBEEF ^ (a - 32'h40) ^ (32'(b) << 24);
    endfunction

    function automatic logic [1:0] resp_of(input int b);
        return (b % 2 == 1) ? 2'b10 : 2'b00;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic issue(input int k, input logic [AW-1:0] addr, input logic [7:0] len, input int again);
        m_req[k]   = 1'b1;
        m_addr[k]  = addr;
        m_len[k]   = len;
        m_again[k] = again;
    endtask

    task automatic expect_ar(input int m, input logic [AW-1:0] addr, input logic [7:0] len, input int short_at);
        exp_ar.push_back('{m, addr, len, id_of(m), short_at});
    endtask

    task automatic drive();
        M_AXI_arvalid = m_req;
        for (int k = 0; k < NM; k++) begin
            M_AXI_arid[k*IW +: IW]   = id_of(k);
            M_AXI_araddr[k*AW +: AW] = m_addr[k];
            M_AXI_arlen[k*8 +: 8]    = m_len[k];
        end
        M_AXI_rready  = (rr_mode == 0 || cyc % 2 == 0) ? '1 : '0;
        S_AXI_arready = !sl_busy && (ar_wait >= ar_delay);
        S_AXI_rvalid  = sl_busy;
        S_AXI_rdata   = beat_data(sl_addr, sl_beat);
        S_AXI_rlast   = sl_busy && (sl_beat == sl_nb - 1);
        S_AXI_rid     = sl_id;
        S_AXI_rresp   = resp_of(sl_beat);
    endtask

    task automatic sample();
        ar_t           a;
        r_t            r;
        logic [NM-1:0] v;

        check("arready_onehot", $countones(M_AXI_arready) <= 1, 1);
        check("rvalid_onehot", $countones(M_AXI_rvalid) <= 1, 1);
        if (tb_data) begin
            v = '0;
            if (S_AXI_rvalid) v[cur_m] = 1'b1;
            check("s_rready_mirror", S_AXI_rready, M_AXI_rready[cur_m]);
            check("m_rvalid_route", M_AXI_rvalid, v);
            check("arready_in_data", M_AXI_arready, 0);
            check("busy_in_data", busy, 1);
        end else begin
            check("s_rready_idle", S_AXI_rready, 0);
            check("m_rvalid_idle", M_AXI_rvalid, 0);
            v = '1;
            if (exp_ar.size() > 0) v[exp_ar[0].m] = 1'b0;
            check("arready_other", M_AXI_arready & v, 0);
        end

        if (S_AXI_arvalid && sarv_first < 0) sarv_first = cyc;

        if (S_AXI_arvalid && S_AXI_arready) begin
            if (exp_ar.size() == 0) begin
                check("ar_unexpected", 1, 0);
            end else begin
                a = exp_ar.pop_front();
                check("ar_grant", grant, a.m);
                check("ar_addr", S_AXI_araddr, a.addr);
                check("ar_len", S_AXI_arlen, a.len);
                check("ar_id", S_AXI_arid, a.id);
                check("ar_size", S_AXI_arsize, 2);
                check("ar_burst", S_AXI_arburst, 1);
                sl_busy = 1'b1;
                sl_addr = a.addr;
                sl_id   = a.id;
                sl_beat = 0;
                sl_nb   = (a.short_at >= 0) ? a.short_at + 1 : int'(a.len) + 1;
                for (int b = 0; b < sl_nb; b++)
                    exp_r.push_back('{a.m, beat_data(a.addr, b), b == sl_nb - 1, a.id, resp_of(b)});
                cur_m   = a.m;
                tb_data = 1'b1;
            end
            ar_wait = 0;
        end else if (S_AXI_arvalid) begin
            ar_wait++;
        end

        for (int k = 0; k < NM; k++) begin
            if (M_AXI_arvalid[k] && M_AXI_arready[k]) begin
                if (m_again[k] > 0) begin
                    m_again[k]--;
                    m_addr[k] = m_addr[k] + 32'h100;
                end else begin
                    m_req[k] = 1'b0;
                end
            end
        end

        for (int k = 0; k < NM; k++) begin
            if (M_AXI_rvalid[k] && M_AXI_rready[k]) begin
                r_cnt++;
                if (exp_r.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    r = exp_r.pop_front();
                    check("r_master", k, r.m);
                    check("r_data", M_AXI_rdata, r.data);
                    check("r_last", M_AXI_rlast, r.last);
                    check("r_id", M_AXI_rid, r.id);
                    check("r_resp", M_AXI_rresp, r.resp);
                end
            end
        end

        if (S_AXI_rvalid && S_AXI_rready) begin
            if (S_AXI_rlast) begin
                sl_busy = 1'b0;
                tb_data = 1'b0;
                if (cyc == req6_cyc) coinc6 = 1'b1;
            end
            sl_beat++;
        end

        // Raise master 0's request so it is visible in the final-beat cycle.
        if (trig6 && sl_busy && sl_beat == sl_nb - 1) begin
            m_req[0]   = 1'b1;
            m_addr[0]  = 32'h6400;
            m_len[0]   = 8'd0;
            m_again[0] = 0;
            req6_cyc   = cyc + 1;
            sarv_first = -1;
            trig6      = 1'b0;
        end
    endtask

    task automatic step();
        cyc++;
        drive();
        #4;
        sample();
        @(posedge ACLK);
        #1;
    endtask

    function automatic bit quiet();
        return exp_ar.size() == 0 && exp_r.size() == 0 && m_req == '0 && !sl_busy;
    endfunction

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while (!quiet() && n < max) begin
            step();
            n++;
        end
        check("run_timeout", quiet(), 1);
        step();
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req1;
        int n;

        ARESETN    = 1'b0;
        m_req      = '0;
        m_addr[0]  = 32'h0A00;
        m_addr[1]  = 32'h0B00;
        m_len[0]   = 8'd5;
        m_len[1]   = 8'd9;
        m_again[0] = 0;
        m_again[1] = 0;
        rr_mode    = 0;
        ar_delay   = 0;
        ar_wait    = 0;
        sl_busy    = 1'b0;
        sl_addr    = '0;
        sl_id      = '0;
        sl_nb      = 1;
        sl_beat    = 0;
        tb_data    = 1'b0;
        cur_m      = 0;
        cyc        = 0;
        sarv_first = -1;
        req6_cyc   = -100;
        trig6      = 1'b0;
        coinc6     = 1'b0;
        r_cnt      = 0;
        n_total    = 0;
        n_bad      = 0;
        drive();
        @(posedge ACLK);
        #1;

        // reset state
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_len_err", len_err, 0);
        check("rst_m_arready", M_AXI_arready, 0);
        check("rst_m_rvalid", M_AXI_rvalid, 0);
        check("rst_s_arvalid", S_AXI_arvalid, 0);
        check("rst_s_rready", S_AXI_rready, 0);
        check("rst_s_araddr", S_AXI_araddr, 32'h0A00);
        check("rst_s_arlen", S_AXI_arlen, 5);
        check("rst_s_arid", S_AXI_arid, id_of(0));
        ARESETN = 1'b1;
        step();

        // single request from master 1
        issue(1, 32'h40, 8'd0, 0);
        expect_ar(1, 32'h40, 8'd0, -1);
        sarv_first = -1;
        req1 = cyc + 1;
        run_idle(50);
        check("t1_ar_latency", sarv_first, req1 + 1);
        check("t1_grant_held", grant, 1);
        check("t1_busy", busy, 0);
        check("t1_len_err", len_err, 0);

        // contention: each master twice, arlen=3
        r_cnt = 0;
        issue(0, 32'h1000, 8'd3, 1);
        issue(1, 32'h2000, 8'd3, 1);
        expect_ar(0, 32'h1000, 8'd3, -1);
        expect_ar(1, 32'h2000, 8'd3, -1);
        expect_ar(0, 32'h1100, 8'd3, -1);
        expect_ar(1, 32'h2100, 8'd3, -1);
        run_idle(300);
        check("t2_beats", r_cnt, 16);
        check("t2_len_err", len_err, 0);

        // back-pressure on AR and R
        ar_delay = 3;
        rr_mode  = 1;
        r_cnt    = 0;
        issue(0, 32'h3000, 8'd3, 0);
        issue(1, 32'h3800, 8'd2, 0);
        expect_ar(0, 32'h3000, 8'd3, -1);
        expect_ar(1, 32'h3800, 8'd2, -1);
        run_idle(300);
        check("t3_beats", r_cnt, 7);
        check("t3_len_err", len_err, 0);
        ar_delay = 0;
        rr_mode  = 0;

        // early rlast, then good bursts keep the sticky flag
        issue(0, 32'h4000, 8'd3, 0);
        expect_ar(0, 32'h4000, 8'd3, 2);
        run_idle(100);
        check("t4_len_err_set", len_err, 1);
        check("t4_busy", busy, 0);
        issue(1, 32'h4400, 8'd1, 0);
        expect_ar(1, 32'h4400, 8'd1, -1);
        run_idle(100);
        check("t4_len_err_sticky1", len_err, 1);
        issue(0, 32'h4800, 8'd2, 0);
        expect_ar(0, 32'h4800, 8'd2, -1);
        run_idle(100);
        check("t4_len_err_sticky2", len_err, 1);

        // new request coinciding with the final rlast handshake
        coinc6 = 1'b0;
        issue(1, 32'h6000, 8'd3, 0);
        expect_ar(1, 32'h6000, 8'd3, -1);
        expect_ar(0, 32'h6400, 8'd0, -1);
        trig6 = 1'b1;
        run_idle(100);
        check("t6_coincide", coinc6, 1);
        check("t6_addr_phase", sarv_first, req6_cyc + 2);
        check("t6_len_err", len_err, 1);

        // reset during beat 2 of an arlen=7 burst from master 1
        r_cnt = 0;
        issue(1, 32'h5000, 8'd7, 0);
        expect_ar(1, 32'h5000, 8'd7, -1);
        n = 0;
        while (r_cnt < 2 && n < 100) begin
            step();
            n++;
        end
        check("t5_reach_beat2", r_cnt, 2);
        ARESETN = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_grant", grant, 0);
        check("t5_len_err", len_err, 0);
        check("t5_m_arready", M_AXI_arready, 0);
        check("t5_m_rvalid", M_AXI_rvalid, 0);
        check("t5_s_arvalid", S_AXI_arvalid, 0);
        check("t5_s_rready", S_AXI_rready, 0);
        exp_ar.delete();
        exp_r.delete();
        sl_busy = 1'b0;
        sl_beat = 0;
        tb_data = 1'b0;
        m_req   = '0;
        ar_wait = 0;
        drive();
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        issue(0, 32'h5800, 8'd1, 0);
        issue(1, 32'h5C00, 8'd1, 0);
        expect_ar(0, 32'h5800, 8'd1, -1);
        expect_ar(1, 32'h5C00, 8'd1, -1);
        run_idle(100);
        check("t5_after_len_err", len_err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
